// File: rtl/clint_pkg.sv
// Shared constants, bus types and address decode for the multi-hart CLINT.
package clint_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MTIME_W   = 64;
    localparam int unsigned MAX_HARTS = 16;
    localparam int unsigned HART_W    = 4;

    localparam logic [11:0]        CLINT_BASE_HI  = 12'h200;
    localparam logic [15:0]        MSIP_BASE      = 16'h0000;
    localparam logic [15:0]        MTIMECMP_BASE  = 16'h4000;
    localparam logic [15:0]        MTIME_LO       = 16'hBFF8;
    localparam logic [15:0]        MTIME_HI       = 16'hBFFC;
    localparam logic [MTIME_W-1:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        TT_READ  = 1'b0,
        TT_WRITE = 1'b1
    } ttype_e;

    // Decoded view of a word offset inside the CLINT window
    typedef struct packed {
        logic              msip;
        logic              mtimecmp;
        logic              mtime_lo;
        logic              mtime_hi;
        logic              hi_word;
        logic [HART_W-1:0] hart;
    } clint_dec_t;

    // Decode a word offset (byte offset bits [15:2]) into register class and hart index
    function automatic clint_dec_t clint_decode(input logic [13:0] woff);
        clint_dec_t d;
        d          = '0;
        d.msip     = (woff[13:4] == MSIP_BASE[15:6]);
        d.mtimecmp = (woff[13:5] == MTIMECMP_BASE[15:7]);
        d.mtime_lo = (woff == MTIME_LO[15:2]);
        d.mtime_hi = (woff == MTIME_HI[15:2]);
        d.hi_word  = woff[0];
        d.hart     = d.msip ? woff[3:0] : woff[4:1];
        return d;
    endfunction

endpackage

// File: rtl/slave_bus_if.sv
// Single-cycle system bus slave interface.
interface slave_bus_if;
    import clint_pkg::*;

    logic              ss;
    ttype_e            ttype;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              bdone;

    modport slave  (input ss, ttype, addr, wdata, output rdata, bdone);
    modport master (output ss, ttype, addr, wdata, input rdata, bdone);
endinterface

// File: rtl/clint_mtime.sv
// 64-bit mtime counter with half-word loads; a load suppresses the increment.
// CLINT_PRESCALER_EN: when defined, mtime advances once every PRESCALE clocks.
module clint_mtime
    import clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_lo,
    input  logic               load_hi,
    input  logic [DATA_W-1:0]  load_data,
    output logic [MTIME_W-1:0] mtime
);

    logic               tick;
    logic [MTIME_W-1:0] mtime_d;

    if (PRESCALE == 0 || PRESCALE > 65536) begin : g_bad_prescale
        $error("clint_mtime: PRESCALE must be 1..65536");
    end

`ifdef CLINT_PRESCALER_EN
    if (PRESCALE == 1) begin : g_no_div
        assign tick = 1'b1;
    end else begin : g_div
        localparam int unsigned    CNT_W    = $clog2(PRESCALE);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

        logic [CNT_W-1:0] cnt;

        // Free-running divider; mtime writes do not disturb its phase
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign tick = (cnt == CNT_LAST);
    end
`else
    assign tick = 1'b1;
`endif

    // Next value: any bus load wins over the tick, and never carries
    always_comb begin
        mtime_d = mtime;
        if (load_lo || load_hi) begin
            if (load_lo) mtime_d[31:0]  = load_data;
            if (load_hi) mtime_d[63:32] = load_data;
        end else if (tick) begin
            mtime_d = mtime + MTIME_W'(1);
        end
    end

    // Counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= '0;
        end else begin
            mtime <= mtime_d;
        end
    end

endmodule

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor: mtime, per-hart mtimecmp/msip, timer and software IRQs.
// CLINT_PRESCALER_EN: when defined, mtime is divided down by PRESCALE (see clint_mtime).
module clint_mh
    import clint_pkg::*;
#(
    parameter int unsigned NUM_HARTS = 1,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    slave_bus_if.slave           bus,
    output logic [NUM_HARTS-1:0] irq_sw,
    output logic [NUM_HARTS-1:0] irq_timer
);

    logic                             sel;
    logic                             wr_en;
    clint_dec_t                       dec;
    logic [MTIME_W-1:0]               mtime;
    logic [NUM_HARTS:0][DATA_W-1:0]   rd_chain;
    logic                             unused_addr;

    if (NUM_HARTS == 0 || NUM_HARTS > MAX_HARTS) begin : g_bad_harts
        $error("clint_mh: NUM_HARTS must be 1..16");
    end

    assign sel         = bus.ss && (bus.addr[27:16] == CLINT_BASE_HI);
    assign wr_en       = sel && (bus.ttype == TT_WRITE);
    assign dec         = clint_decode(bus.addr[15:2]);
    assign unused_addr = ^{bus.addr[31:28], bus.addr[1:0]};

    clint_mtime #(
        .PRESCALE (PRESCALE)
    ) u_mtime (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_lo   (wr_en && dec.mtime_lo),
        .load_hi   (wr_en && dec.mtime_hi),
        .load_data (bus.wdata),
        .mtime     (mtime)
    );

    assign rd_chain[0] = '0;

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        localparam logic [HART_W-1:0] HART_ID = HART_W'(h);

        logic               hart_sel;
        logic               hart_wr;
        logic               msip_q;
        logic               irq_q;
        logic [MTIME_W-1:0] cmp_q;
        logic [DATA_W-1:0]  hart_rd;

        assign hart_sel = sel && (dec.hart == HART_ID);
        assign hart_wr  = hart_sel && (bus.ttype == TT_WRITE);

        // Per-hart msip, mtimecmp and registered timer compare
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                msip_q <= 1'b0;
                cmp_q  <= MTIMECMP_RESET;
                irq_q  <= 1'b0;
            end else begin
                if (hart_wr && dec.msip) msip_q <= bus.wdata[0];
                if (hart_wr && dec.mtimecmp && !dec.hi_word) cmp_q[31:0]  <= bus.wdata;
                if (hart_wr && dec.mtimecmp &&  dec.hi_word) cmp_q[63:32] <= bus.wdata;
                irq_q <= (mtime >= cmp_q);
            end
        end

        // Readback contribution of this hart, zero when not addressed
        always_comb begin
            hart_rd = '0;
            if (hart_sel && dec.msip) begin
                hart_rd = {31'd0, msip_q};
            end else if (hart_sel && dec.mtimecmp) begin
                hart_rd = dec.hi_word ? cmp_q[63:32] : cmp_q[31:0];
            end
        end

        assign rd_chain[h+1] = rd_chain[h] | hart_rd;
        assign irq_sw[h]     = msip_q;
        assign irq_timer[h]  = irq_q;
    end

    // Combinational read mux; unmapped and deselected reads return 0
    always_comb begin
        bus.rdata = '0;
        if (sel && dec.mtime_lo) begin
            bus.rdata = mtime[31:0];
        end else if (sel && dec.mtime_hi) begin
            bus.rdata = mtime[63:32];
        end else begin
            bus.rdata = rd_chain[NUM_HARTS];
        end
    end

    assign bus.bdone = 1'b1;

endmodule

// File: tb/tb_clint_mh.sv
// Scoreboard bench for clint_mh with two harts; expected values are hand-computed per cycle.
module tb_clint_mh;
    import clint_pkg::*;

    localparam int unsigned NH = 2;
`ifdef CLINT_PRESCALER_EN
    localparam int unsigned PS = 4;
`else
    localparam int unsigned PS = 1;
`endif

    typedef enum logic [1:0] {K_RD, K_TMR, K_SW} kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NH-1:0] irq_sw;
    logic [NH-1:0] irq_timer;
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    slave_bus_if bus_if();

    clint_mh #(
        .NUM_HARTS (NH),
        .PRESCALE  (PS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .irq_sw    (irq_sw),
        .irq_timer (irq_timer)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop every expectation tagged for this cycle and compare mid-cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        logic        ok;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e  = sb.pop_front();
            ok = (e.cyc == cyc);
            vectors++;
            case (e.kind)
                K_RD: begin
                    act = bus_if.rdata;
                    ok  = ok && bus_if.ss && (bus_if.ttype == TT_READ) && (bus_if.bdone === 1'b1);
                end
                K_TMR:   act = 32'(irq_timer);
                default: act = 32'(irq_sw);
            endcase
            ok = ok && (act === e.exp);
            if (!ok) begin
                miscompares++;
                $display("FAIL %s (cycle %0d, due %0d): got 0x%08h bdone=%b, expected 0x%08h",
                         e.name, cyc, e.cyc, act, bus_if.bdone, e.exp);
            end
        end
    end

    task automatic expect_val(input kind_e k, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        bus_if.ss    = 1'b0;
        bus_if.ttype = TT_READ;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    task automatic rd_at(input logic [31:0] a, input logic [31:0] v, input string name);
        next_cycle();
        bus_if.ss    = 1'b1;
        bus_if.ttype = TT_READ;
        bus_if.addr  = a;
        expect_val(K_RD, v, name);
    endtask

    task automatic rd(input logic [15:0] off, input logic [31:0] v, input string name);
        rd_at({16'h0200, off}, v, name);
    endtask

    task automatic wr(input logic [15:0] off, input logic [31:0] d);
        next_cycle();
        bus_if.ss    = 1'b1;
        bus_if.ttype = TT_WRITE;
        bus_if.addr  = {16'h0200, off};
        bus_if.wdata = d;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus_if.ss    = 1'b0;
        bus_if.ttype = TT_READ;
        bus_if.addr  = '0;
        bus_if.wdata = '0;
        idle(2);
        #2;
        vectors++;
        if (irq_timer !== '0) begin
            miscompares++;
            $display("FAIL direct_rst_irq_timer: got %b, expected 0", irq_timer);
        end
        vectors++;
        if (irq_sw !== '0) begin
            miscompares++;
            $display("FAIL direct_rst_irq_sw: got %b, expected 0", irq_sw);
        end
        vectors++;
        if (bus_if.bdone !== 1'b1) begin
            miscompares++;
            $display("FAIL direct_bdone: got %b, expected 1", bus_if.bdone);
        end
        rd(16'hBFF8, 32'h0, "rst_mtime_lo");
        expect_val(K_TMR, 32'd0, "rst_irq_timer");
        expect_val(K_SW, 32'd0, "rst_irq_sw");
        rd(16'h4004, 32'hFFFF_FFFF, "rst_cmp0_hi");

        // Release: this cycle is C0 with mtime = 0
        next_cycle();
        rst_n = 1'b1;

`ifdef CLINT_PRESCALER_EN
        idle(15);                                          // C1..C15
        rd(16'hBFF8, 32'd4, "ps_mtime_after_16");          // C16
        expect_val(K_TMR, 32'd0, "ps_irq_timer");
        idle(2);                                           // C17..C18
        wr(16'hBFF8, 32'd100);                             // C19 is a tick cycle
        rd(16'hBFF8, 32'd100, "ps_load_beats_tick");       // C20
        idle(2);                                           // C21..C22
        rd(16'hBFF8, 32'd100, "ps_hold_before_tick");      // C23
        rd(16'hBFF8, 32'd101, "ps_after_tick");            // C24
        rd(16'hBFFC, 32'd0, "ps_mtime_hi");                // C25
        rd(16'h4000, 32'hFFFF_FFFF, "ps_cmp0_lo");         // C26
        expect_val(K_SW, 32'd0, "ps_irq_sw");
`else
        idle(9);                                           // C1..C9
        rd(16'hBFF8, 32'd10, "mtime_after_10");            // C10
        expect_val(K_TMR, 32'd0, "irq_timer_idle");
        rd(16'h4000, 32'hFFFF_FFFF, "cmp0_lo_reset");      // C11
        rd(16'h4004, 32'hFFFF_FFFF, "cmp0_hi_reset");      // C12
        rd(16'hBFFC, 32'd0, "mtime_hi_zero");              // C13

        wr(16'h4008, 32'd20);                              // C14
        wr(16'h400C, 32'd0);                               // C15
        next_cycle();                                      // C16
        expect_val(K_TMR, 32'd0, "cmp1_set_no_irq");
        idle(3);                                           // C17..C19
        rd(16'hBFF8, 32'd20, "mtime_reaches_20");          // C20
        expect_val(K_TMR, 32'd0, "irq1_not_yet");
        next_cycle();                                      // C21
        expect_val(K_TMR, 32'd2, "irq1_rises");
        rd(16'h4008, 32'd20, "cmp1_lo_readback");          // C22

        wr(16'h0004, 32'hFFFF_FFFF);                       // C23
        rd(16'h0004, 32'd1, "msip1_readback");             // C24
        expect_val(K_SW, 32'd2, "irq_sw1_set");
        rd(16'h0000, 32'd0, "msip0_untouched");            // C25
        wr(16'h0004, 32'd0);                               // C26
        next_cycle();                                      // C27
        expect_val(K_SW, 32'd0, "irq_sw1_clear");

        wr(16'h2000, 32'h0000_DEAD);                       // C28
        rd(16'h2000, 32'd0, "unmapped_read");              // C29
        wr(16'h0008, 32'd1);                               // C30
        rd(16'h0008, 32'd0, "msip_hart2_read");            // C31
        expect_val(K_SW, 32'd0, "msip_hart2_no_effect");
        wr(16'h4010, 32'd0);                               // C32
        rd(16'h4010, 32'd0, "cmp_hart2_read");             // C33
        next_cycle();                                      // C34
        expect_val(K_TMR, 32'd2, "cmp_hart2_no_effect");
        rd_at(32'h0300_BFF8, 32'd0, "wrong_base");         // C35
        rd_at(32'h0200_4003, 32'hFFFF_FFFF, "addr_lsb_ignored"); // C36

        wr(16'h4000, 32'd5);                               // C37
        wr(16'h4004, 32'd0);                               // C38
        next_cycle();                                      // C39
        expect_val(K_TMR, 32'd2, "irq0_after_lo_only");
        next_cycle();                                      // C40
        expect_val(K_TMR, 32'd3, "irq0_rises");

        wr(16'hBFFC, 32'hFFFF_FFFF);                       // C41, mtime was 41
        rd(16'hBFF8, 32'd41, "no_increment_on_load");      // C42
        rd(16'hBFFC, 32'hFFFF_FFFF, "mtime_hi_loaded");    // C43
        wr(16'hBFF8, 32'hFFFF_FFFE);                       // C44
        rd(16'hBFF8, 32'hFFFF_FFFE, "mtime_lo_loaded");    // C45
        rd(16'hBFFC, 32'hFFFF_FFFF, "mtime_all_ones");     // C46
        expect_val(K_TMR, 32'd3, "irq_before_wrap");
        rd(16'hBFFC, 32'd0, "mtime_wrapped_hi");           // C47
        expect_val(K_TMR, 32'd3, "irq_at_wrap");
        rd(16'hBFF8, 32'd1, "mtime_after_wrap");           // C48
        expect_val(K_TMR, 32'd0, "irq_drops_after_wrap");
        idle(3);                                           // C49..C51
        rd(16'hBFF8, 32'd5, "mtime_back_to_5");            // C52
        expect_val(K_TMR, 32'd0, "irq0_not_yet_again");
        next_cycle();                                      // C53
        expect_val(K_TMR, 32'd1, "irq0_rises_again");

        wr(16'h0000, 32'd1);                               // C54
        next_cycle();                                      // C55
        expect_val(K_SW, 32'd1, "irq_sw0_set");

        wr(16'h4000, 32'd0);                               // C56, lost to reset
        #2;
        rst_n = 1'b0;
        expect_val(K_TMR, 32'd0, "async_reset_irq_timer");
        expect_val(K_SW, 32'd0, "async_reset_irq_sw");
        rd(16'h4000, 32'hFFFF_FFFF, "write_lost_in_reset"); // C57
        rd(16'hBFF8, 32'd0, "mtime_after_reset");          // C58
        rst_n = 1'b1;
        rd(16'hBFF8, 32'd1, "mtime_restarts");             // C59
`endif

        idle(2);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: never compared, expected 0x%08h", e.name, e.exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        if (miscompares == 0) begin
            $display("PASS");
        end
        $finish;
    end

endmodule

// File: doc/clint_mh.md
# clint_mh

Multi-hart core-local interruptor: the successor to the single-hart timer block. It provides a 64-bit free-running `mtime` with an optional tick prescaler, one 64-bit `mtimecmp` and one `msip` register per hart, and per-hart registered timer and software interrupt outputs. It sits on the system bus as a single-cycle slave in the 0x0200_0000 window and drives `mip.MTIP`/`mip.MSIP` of each hart.

## Interface
- `NUM_HARTS`, 1: number of harts, 1..16.
- `PRESCALE`, 1: `mtime` increments once every `PRESCALE` clk cycles, 1..65536. Used only with `CLINT_PRESCALER_EN`.
- `clk` in 1: clock clk.
- `rst_n` in 1: reset rst_n, asynchronous, active-low.
- `bus` slave_bus_if.slave: `ss`, `ttype` (READ/WRITE), `addr[31:0]`, `wdata[31:0]`, `rdata[31:0]`, `bdone`.
- `irq_sw` out NUM_HARTS: per-hart machine software interrupt, equal to `msip[h]`.
- `irq_timer` out NUM_HARTS: per-hart machine timer interrupt, registered.

## Operation
- Decode: the block is selected when `addr[27:16] == 12'h200`. The offset is `addr[15:0]`. All accesses are word-sized and word-aligned, and `addr[1:0]` is ignored.
- Register map (offset):
  - `msip[h]` at 0x0000 + 4h. Only bit 0 is writable; the other bits read as 0.
  - `mtimecmp[h]` low word at 0x4000 + 8h, high word at 0x4004 + 8h.
  - `mtime` low word at 0xBFF8, high word at 0xBFFC.
  - Offsets for h ≥ NUM_HARTS and all other offsets are unmapped: reads return 0 and writes are ignored.
- `bdone` is 1 every cycle. `rdata` is combinational from the decoded address and is 0 when `ss` is 0.
- `mtime` is a 64-bit unsigned counter that wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- Writes to `mtime`:
  - A bus write to either half of `mtime` loads that half from `wdata`. The other half holds.
  - The increment is suppressed for the whole 64-bit value in that cycle. The bus write wins and there is no carry.
- `irq_timer[h]` is registered from `mtime >= mtimecmp[h]`, a 64-bit unsigned compare.
- `irq_sw[h]` is the `msip[h]` flop driven directly.
- Reset values:
  - `mtime` = 0.
  - All `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF, so there is no interrupt out of reset.
  - All `msip` = 0, `irq_timer` = 0, `irq_sw` = 0.
  - Prescaler count = 0.
- Reset asserted mid-operation clears all state asynchronously. A bus write in progress is lost.

## Timing
- A bus write takes effect at the clk edge that ends the cycle in which `ss` = 1 and `ttype` = WRITE.
- A read returns the pre-edge value in the same cycle.
- `irq_timer` changes 1 cycle after the edge at which `mtime` or `mtimecmp` changes.
- `irq_sw` changes on the write edge.
- Prescaler:
  - The tick asserts when the prescaler count equals PRESCALE-1. The count then returns to 0.
  - `mtime` increments on tick edges only.
  - A write to `mtime` does not reset the prescaler.
- Wrap boundary: when `mtime` wraps to 0 with `mtimecmp` = 5, `irq_timer` deasserts 1 cycle after the wrap.
- A simultaneous `mtimecmp` write and compare crossing resolves on the post-write values.

## Configuration
- `CLINT_PRESCALER_EN` defined: the prescaler counter of width `$clog2(PRESCALE)` is instantiated. When PRESCALE = 1 the tick is constantly 1.
- `CLINT_PRESCALER_EN` undefined: there is no prescaler logic, `PRESCALE` is ignored, and `mtime` increments every clk cycle.

## Structure
- Shared package `clint_pkg` holds:
  - `CLINT_BASE_HI` = 12'h200.
  - Offset constants `MSIP_BASE`, `MTIMECMP_BASE`, `MTIME_LO`, `MTIME_HI`.
  - `MTIMECMP_RESET` = 64'hFFFF_FFFF_FFFF_FFFF.
- Sub-module `clint_mtime`: 64-bit counter with prescaler, half-word load ports and increment suppression.
- The top level holds address decode, the per-hart register array (generate loop) and the compare flops.

## Test plan
- Reset, then 10 cycles idle with `CLINT_PRESCALER_EN` undefined → `mtime` = 10, `irq_timer` = 0, reads of 0x4000 and 0x4004 return 0xFFFF_FFFF.
- NUM_HARTS = 2: write 0x4008 = 20 and 0x400C = 0 → `irq_timer[1]` rises exactly 1 cycle after `mtime` reaches 20, and `irq_timer[0]` stays 0.
- Write 0x0004 = 0xFFFF_FFFF → `irq_sw[1]` = 1 on the next edge, and a read of 0x0004 returns 0x1. Write 0 → `irq_sw[1]` = 0.
- Write 0xBFF8 = 0xFFFF_FFFF and 0xBFFC = 0xFFFF_FFFF with `mtimecmp[0]` = 5 → the counter wraps to 0 and `irq_timer[0]` drops 1 cycle later.
- `CLINT_PRESCALER_EN` defined, PRESCALE = 4: 16 idle cycles → `mtime` = 4. A write to 0xBFF8 = 100 coincident with a tick → `mtime` = 100, not 101.
- Access unmapped offset 0x2000 and `msip` for h = NUM_HARTS → reads return 0, writes change no state, `bdone` = 1.
